// File: rtl/aes_dec_pkg.sv
// Shared types and GF(2^8) helpers for the AES decryption datapath.
// Holds the InvMixColumns FSM encoding and the 0x09/0x0b/0x0d/0x0e multipliers.
package aes_dec_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_COL_W   = 32;
  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } fsm_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul_09(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul_0b(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul_0d(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul_0e(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/inv_mix_single_column.sv
// Combinational InvMixColumns of one 32-bit column (byte 0 is the MSB).
// Ports: col_i (input column), col_o (transformed column).
module inv_mix_single_column
  import aes_dec_pkg::*;
(
  input  logic [AES_COL_W-1:0] col_i,
  output logic [AES_COL_W-1:0] col_o
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col_i[31:24];
  assign a1 = col_i[23:16];
  assign a2 = col_i[15:8];
  assign a3 = col_i[7:0];

  // Circulant rows of the {0e,0b,0d,09} matrix.
  assign col_o[31:24] = gf_mul_0e(a0) ^ gf_mul_0b(a1)
                      ^ gf_mul_0d(a2) ^ gf_mul_09(a3);
  assign col_o[23:16] = gf_mul_0e(a1) ^ gf_mul_0b(a2)
                      ^ gf_mul_0d(a3) ^ gf_mul_09(a0);
  assign col_o[15:8]  = gf_mul_0e(a2) ^ gf_mul_0b(a3)
                      ^ gf_mul_0d(a0) ^ gf_mul_09(a1);
  assign col_o[7:0]   = gf_mul_0e(a3) ^ gf_mul_0b(a0)
                      ^ gf_mul_0d(a1) ^ gf_mul_09(a2);

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequential AES InvMixColumns: one state in via valid/ready, columns
// transformed through a shared engine, result held until accepted.
// Ports: MainClock/MainReset (async, active-high); state_in, state_in_vld,
// state_in_rdy, inv_mix_column_off (bypass, sampled on accept);
// state_out, state_out_vld, state_out_rdy.
// Build option INV_MIX_COLUMNS_DUAL_EN: two engines, two columns per cycle.
module inv_mix_columns_seq
  import aes_dec_pkg::*;
#(
  parameter int COLS = 4
) (
  input  logic                   MainClock,
  input  logic                   MainReset,
  input  logic [AES_STATE_W-1:0] state_in,
  input  logic                   state_in_vld,
  output logic                   state_in_rdy,
  input  logic                   inv_mix_column_off,
  output logic [AES_STATE_W-1:0] state_out,
  output logic                   state_out_vld,
  input  logic                   state_out_rdy
);

  localparam int CW = $clog2(COLS);

`ifdef INV_MIX_COLUMNS_DUAL_EN
  localparam logic [CW-1:0] STEP = CW'(2);
  localparam logic [CW-1:0] LAST = CW'(COLS - 2);
`else
  localparam logic [CW-1:0] STEP = CW'(1);
  localparam logic [CW-1:0] LAST = CW'(COLS - 1);
`endif

  fsm_t                   state_q, state_d;
  logic [CW-1:0]          col_cnt_q, col_cnt_d;
  logic [AES_STATE_W-1:0] data_q, data_d;
  logic                   off_q, off_d;

  logic                   accept;
  logic [AES_COL_W-1:0]   col_a_in, col_a_out;

  always_comb begin
    col_a_in = '0;
    for (int c = 0; c < COLS; c++) begin
      if (col_cnt_q == CW'(c))
        col_a_in = data_q[AES_STATE_W-1-AES_COL_W*c -: AES_COL_W];
    end
  end

  inv_mix_single_column u_col_a (
    .col_i (col_a_in),
    .col_o (col_a_out)
  );

`ifdef INV_MIX_COLUMNS_DUAL_EN
  logic [CW-1:0]        col_nxt;
  logic [AES_COL_W-1:0] col_b_in, col_b_out;

  assign col_nxt = col_cnt_q + CW'(1);

  always_comb begin
    col_b_in = '0;
    for (int c = 0; c < COLS; c++) begin
      if (col_nxt == CW'(c))
        col_b_in = data_q[AES_STATE_W-1-AES_COL_W*c -: AES_COL_W];
    end
  end

  inv_mix_single_column u_col_b (
    .col_i (col_b_in),
    .col_o (col_b_out)
  );
`endif

  // Ready is forced low during reset so nothing is offered mid-reset.
  always_comb begin
    state_in_rdy = 1'b0;
    if (!MainReset) begin
      unique case (state_q)
        IDLE:    state_in_rdy = 1'b1;
        DONE:    state_in_rdy = state_out_rdy;
        default: state_in_rdy = 1'b0;
      endcase
    end
  end

  assign accept        = state_in_vld && state_in_rdy;
  assign state_out     = data_q;
  assign state_out_vld = (state_q == DONE);

  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    data_d    = data_q;
    off_d     = off_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          data_d    = state_in;
          off_d     = inv_mix_column_off;
          col_cnt_d = '0;
          state_d   = inv_mix_column_off ? DONE : CALC;
        end
      end
      CALC: begin
        // A bypassed state never reaches here; the guard keeps it untouched.
        if (off_q) begin
          col_cnt_d = '0;
          state_d   = DONE;
        end else begin
          for (int c = 0; c < COLS; c++) begin
            if (col_cnt_q == CW'(c))
              data_d[AES_STATE_W-1-AES_COL_W*c -: AES_COL_W] = col_a_out;
`ifdef INV_MIX_COLUMNS_DUAL_EN
            if (col_nxt == CW'(c))
              data_d[AES_STATE_W-1-AES_COL_W*c -: AES_COL_W] = col_b_out;
`endif
          end
          if (col_cnt_q == LAST) begin
            col_cnt_d = '0;
            state_d   = DONE;
          end else begin
            col_cnt_d = col_cnt_q + STEP;
          end
        end
      end
      DONE: begin
        if (state_out_rdy) begin
          if (accept) begin
            data_d    = state_in;
            off_d     = inv_mix_column_off;
            col_cnt_d = '0;
            state_d   = inv_mix_column_off ? DONE : CALC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        col_cnt_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge MainClock or posedge MainReset) begin
    if (MainReset) begin
      state_q   <= IDLE;
      col_cnt_q <= '0;
      data_q    <= '0;
      off_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      data_q    <= data_d;
      off_q     <= off_d;
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Self-checking bench for inv_mix_columns_seq against a matrix-level
// GF(2^8) reference model (handles the INV_MIX_COLUMNS_DUAL_EN build too).
module tb_inv_mix_columns_seq;

`ifdef INV_MIX_COLUMNS_DUAL_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 4;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] s_in = '0;
  logic         s_vld = 1'b0;
  logic         s_rdy;
  logic         off = 1'b0;
  logic [127:0] s_out;
  logic         o_vld;
  logic         o_rdy = 1'b1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  inv_mix_columns_seq dut (
    .MainClock          (clk),
    .MainReset          (rst),
    .state_in           (s_in),
    .state_in_vld       (s_vld),
    .state_in_rdy       (s_rdy),
    .inv_mix_column_off (off),
    .state_out          (s_out),
    .state_out_vld      (o_vld),
    .state_out_rdy      (o_rdy)
  );

  // Generic shift-and-add GF(2^8) multiply, reduction by 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // out[r] = sum_k coef[k] * a[(r+k) mod 4], for every column.
  function automatic logic [127:0] mix(input logic [127:0] s, input logic [31:0] coef);
    logic [127:0] o;
    logic [7:0] acc, cf, ab;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) begin
          cf = coef[31-8*k -: 8];
          ab = s[127-32*c-8*((r+k)%4) -: 8];
          acc = acc ^ gmul(cf, ab);
        end
        o[127-32*c-8*r -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] inv_ref(input logic [127:0] s);
    return mix(s, 32'h0e0b0d09);
  endfunction

  function automatic logic [127:0] fwd_ref(input logic [127:0] s);
    return mix(s, 32'h02030101);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer a state; returns #1 after the accept edge with vld dropped.
  task automatic send(input logic [127:0] d, input logic b);
    int n;
    s_in = d;
    off = b;
    s_vld = 1'b1;
    n = 0;
    while (s_rdy !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_timeout", {127'd0, s_rdy}, 128'd1);
    @(posedge clk); #1;
    s_vld = 1'b0;
    off = $urandom_range(0, 1);
  endtask

  // Count edges from the accept edge until state_out_vld is seen.
  task automatic wait_out(input string tag, input logic [127:0] exp, input int lat);
    int n;
    n = 0;
    while (o_vld !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_vld"}, {127'd0, o_vld}, 128'd1);
    chk({tag, "_lat"}, 128'(n), 128'(lat));
    chk({tag, "_data"}, s_out, exp);
  endtask

  initial begin
    logic [127:0] x, y, hold;
    logic b;

    // Reset state
    #1;
    chk("rst_rdy", {127'd0, s_rdy}, 128'd0);
    chk("rst_vld", {127'd0, o_vld}, 128'd0);
    chk("rst_out", s_out, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("idle_rdy", {127'd0, s_rdy}, 128'd1);

    // FIPS-197 column vectors
    send(128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, 1'b0);
    wait_out("fips", 128'hdb135345_f20a225c_01010101_d4d4d4d5, LAT);

    // Bypass
    send(128'h00112233_44556677_8899aabb_ccddeeff, 1'b1);
    wait_out("bypass", 128'h00112233_44556677_8899aabb_ccddeeff, 0);

    // Random forward reference check
    for (int i = 0; i < 20; i++) begin
      x = rnd128();
      send(x, 1'b0);
      wait_out("rand", inv_ref(x), LAT);
    end

    // Round trip through encryption MixColumns
    for (int i = 0; i < 1000; i++) begin
      x = rnd128();
      send(fwd_ref(x), 1'b0);
      wait_out("roundtrip", x, LAT);
    end
    @(posedge clk); #1;

    // Backpressure
    o_rdy = 1'b0;
    x = rnd128();
    send(x, 1'b0);
    wait_out("bp_first", inv_ref(x), LAT);
    hold = s_out;
    y = rnd128();
    s_in = y;
    off = 1'b0;
    s_vld = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_stable", s_out, hold);
      chk("bp_in_rdy", {127'd0, s_rdy}, 128'd0);
      chk("bp_out_vld", {127'd0, o_vld}, 128'd1);
    end
    o_rdy = 1'b1;
    #1;
    chk("bp_release_rdy", {127'd0, s_rdy}, 128'd1);
    @(posedge clk); #1;
    s_vld = 1'b0;
    wait_out("bp_b2b", inv_ref(y), LAT);
    @(posedge clk); #1;

    // Reset in the middle of CALC (col_cnt == 2)
    send(rnd128(), 1'b0);
    repeat (LAT / 2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_vld", {127'd0, o_vld}, 128'd0);
    chk("midrst_out", s_out, 128'd0);
    chk("midrst_rdy", {127'd0, s_rdy}, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_idle_rdy", {127'd0, s_rdy}, 128'd1);
    x = rnd128();
    send(x, 1'b0);
    wait_out("after_rst", inv_ref(x), LAT);

    // Streaming, alternating bypass, out_rdy tied high
    for (int i = 0; i < 8; i++) begin
      x = rnd128();
      b = i[0];
      send(x, b);
      wait_out("stream", b ? x : inv_ref(x), b ? 0 : LAT);
    end
    @(posedge clk); #1;
    chk("stream_end_vld", {127'd0, o_vld}, 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
